// File: rtl/fp_share_pkg.sv
// Shared definitions for the fp16 adder sharing block.
// Holds the default parameters, fp16 constants and the shadow-stage record.
// The shadow record follows each operation through the core.
// Its tag field is sized for the largest supported requester count (8).
package fp_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 16;
  localparam int LAT_DEF  = 2;

  // Widest owner tag, enough for up to 8 requesters.
  localparam int TAG_W = 3;

  localparam logic [15:0] FP16_ZERO  = 16'h0000;
  localparam logic [15:0] FP16_ONE   = 16'h3C00;
  localparam logic [15:0] FP16_TWO   = 16'h4000;
  localparam logic [15:0] FP16_THREE = 16'h4200;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
  } shadow_t;

endpackage

// File: rtl/hadd_share_arbiter_rr.sv
// Purely combinational round-robin arbiter.
// The search for a winner starts at i_ptr and wraps around.
// The pointer register is held in the parent.
//   i_req    : request vector
//   i_en     : when 0, no grant is produced
//   i_ptr    : index where the circular search starts
//   o_grant  : one-hot grant
//   o_winner : binary index of the granted requester
//   o_any    : 1 when some requester is granted
module rr_arbiter
  import fp_share_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_winner,
  output logic            o_any
);

  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  logic [2*NREQ-1:0] w_req2;
  logic [NREQ-1:0]   w_rot;
  logic [IDW:0]      w_sum;

  // Rotate the requests so that position 0 is the requester at i_ptr.
  assign w_req2 = {i_req, i_req};
  assign w_rot  = NREQ'(w_req2 >> i_ptr);

  always_comb begin
    o_any    = 1'b0;
    o_winner = '0;
    o_grant  = '0;
    w_sum    = '0;
    if (i_en) begin
      // Scan from the far end down, so the last hit is the one closest to i_ptr.
      for (int j = NREQ - 1; j >= 0; j--) begin
        if (w_rot[j]) begin
          w_sum = {1'b0, i_ptr} + (IDW + 1)'(j);
          o_any = 1'b1;
        end
      end
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      o_winner = w_sum[IDW-1:0];
      for (int i = 0; i < NREQ; i++)
        o_grant[i] = o_any && (o_winner == IDW'(i));
    end
  end

endmodule

// File: rtl/hadd_share_arbiter.sv
// Shares one pipelined fp16 adder core among NREQ requesters.
// Operations are issued round-robin.
// A shadow pipeline of {valid, owner} follows each operation through the core.
// Each result is returned to the requester that issued it.
// If that owner is not ready, the core is frozen through its clock enable.
//   aclk, areset          : clock, async active-high reset
//   req_valid/req_ready   : per-requester request handshake
//   req_a/req_b           : packed operands, requester i at [i*DW +: DW]
//   rsp_valid/rsp_ready   : per-requester response handshake (rsp_valid one-hot)
//   rsp_data              : result broadcast to all requesters
//   core_aclken           : clock enable to the core
//   core_a/core_b         : operands to the core
//   core_result           : result from the core
module hadd_share_arbiter
  import fp_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int LAT  = LAT_DEF
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_data,
  input  logic [NREQ-1:0]  rsp_ready,
  output logic             core_aclken,
  output logic [DW-1:0]    core_a,
  output logic [DW-1:0]    core_b,
  input  logic [DW-1:0]    core_result
);

  localparam int IDW = $clog2(NREQ);

  shadow_t        r_shadow [LAT];
  logic [IDW-1:0] r_ptr;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_winner;
  logic [IDW-1:0]  w_ptr_nxt;
  logic            w_issue;
  logic            w_stall;
  logic            w_en;

  // The output stage is decoded from registered state only, so req_valid has no path to rsp_valid.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++)
      rsp_valid[i] = r_shadow[LAT-1].v && (r_shadow[LAT-1].tag == TAG_W'(i));
  end

  assign rsp_data = core_result;

  // rsp_valid is one-hot, so this selects exactly the owner's ready.
  assign w_stall     = |(rsp_valid & ~rsp_ready);
  assign w_en        = ~w_stall & ~areset;
  assign core_aclken = w_en;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req    (req_valid),
    .i_en     (w_en),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_issue)
  );

  assign req_ready = w_grant;
  assign w_ptr_nxt = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);

  always_comb begin
    core_a = '0;
    core_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        core_a = req_a[i*DW +: DW];
        core_b = req_b[i*DW +: DW];
      end
    end
  end

  // The shadow shifts only on enabled edges, so it stays aligned with the core stages.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int s = 0; s < LAT; s++) r_shadow[s] <= '0;
      r_ptr <= '0;
    end else if (w_en) begin
      r_shadow[0].v   <= w_issue;
      r_shadow[0].tag <= TAG_W'(w_winner);
      for (int s = 1; s < LAT; s++) r_shadow[s] <= r_shadow[s-1];
      if (w_issue) r_ptr <= w_ptr_nxt;
    end
  end

endmodule
